// File: rtl/inst_align_buf_pkg.sv
// inst_align_buf_pkg: shared instruction and fetch-line width constants for the alignment buffer
package inst_align_buf_pkg;
  localparam int RV32_INST_WIDTH = 32;
  localparam int IMEM_DATA_WIDTH = 128;
  typedef logic [RV32_INST_WIDTH-1:0] inst_t;
endpackage

// File: rtl/inst_align_buf_if.sv
// inst_align_if: fetch-side and dispatch-side signals of the instruction alignment buffer
interface inst_align_if import inst_align_buf_pkg::*; #(
  parameter int FETCH_W = 4,
  parameter int DISP_W = 2,
  parameter int DEPTH = 8
);
  logic i_flush;
  logic i_fetch_vld;
  logic [FETCH_W*RV32_INST_WIDTH-1:0] i_fetch_data;
  logic [$clog2(FETCH_W)-1:0] i_fetch_ofs;
  logic o_fetch_rdy;
  logic [DISP_W-1:0] o_inst_vld;
  logic [DISP_W*RV32_INST_WIDTH-1:0] o_inst;
  logic [$clog2(DISP_W):0] i_deq_num;
  logic [$clog2(DEPTH):0] o_count;
  modport master (
    output i_flush, i_fetch_vld, i_fetch_data, i_fetch_ofs, i_deq_num,
    input o_fetch_rdy, o_inst_vld, o_inst, o_count
  );
  modport slave (
    input i_flush, i_fetch_vld, i_fetch_data, i_fetch_ofs, i_deq_num,
    output o_fetch_rdy, o_inst_vld, o_inst, o_count
  );
endinterface

// File: rtl/inst_align_wr.sv
// inst_align_wr: per-entry write enable and source slot for a fetch line landing at the tail
module inst_align_wr #(
  parameter int FETCH_W = 4,
  parameter int DEPTH = 8
) (
  input logic en,
  input logic [$clog2(DEPTH)-1:0] tail,
  input logic [$clog2(FETCH_W)-1:0] ofs,
  output logic [DEPTH-1:0] we,
  output logic [DEPTH-1:0][$clog2(FETCH_W)-1:0] slot
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(FETCH_W);
  localparam int CW = AW + 1;
  logic [DEPTH-1:0][AW-1:0] rel;
  // rel is the entry's distance from tail; entries within n = FETCH_W-ofs of tail take slot ofs+rel
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      rel[e] = AW'(e) - tail;
      we[e] = en && (CW'(rel[e]) + CW'(ofs) < CW'(FETCH_W));
      slot[e] = OW'(rel[e]) + ofs;
    end
  end
endmodule

// File: rtl/inst_align_buf.sv
// inst_align_buf: circular instruction FIFO realigning fetch lines into contiguous dispatch lanes
module inst_align_buf import inst_align_buf_pkg::*; #(
  parameter int FETCH_W = 4,
  parameter int DISP_W = 2,
  parameter int DEPTH = 8
) (
  input logic i_clk,
  input logic i_rst_n,
  inst_align_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(FETCH_W);
  logic [CW-1:0] head, tail, count, n, deq, vld_cnt;
  logic rdy, enq;
  logic [FETCH_W-1:0][RV32_INST_WIDTH-1:0] line;
  logic [DISP_W-1:0][RV32_INST_WIDTH-1:0] lanes;
  logic [DISP_W-1:0] vld;
  logic [DEPTH-1:0] we;
  logic [DEPTH-1:0][OW-1:0] slot;
  inst_t mem [DEPTH];
  assign line = bus.i_fetch_data;
  assign rdy = CW'(DEPTH) - count >= CW'(FETCH_W);
  assign enq = bus.i_fetch_vld && rdy && !bus.i_flush;
  assign n = CW'(FETCH_W) - CW'(bus.i_fetch_ofs);
  assign vld_cnt = count < CW'(DISP_W) ? count : CW'(DISP_W);
  // over-requested dequeues clamp to the lanes actually valid
  assign deq = CW'(bus.i_deq_num) > vld_cnt ? vld_cnt : CW'(bus.i_deq_num);
  inst_align_wr #(.FETCH_W(FETCH_W), .DEPTH(DEPTH)) u_wr (
    .en(enq),
    .tail(tail[AW-1:0]),
    .ofs(bus.i_fetch_ofs),
    .we(we),
    .slot(slot)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (bus.i_flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + deq;
      tail <= tail + (enq ? n : '0);
      count <= count + (enq ? n : '0) - deq;
    end
  end
  always_ff @(posedge i_clk) begin
    for (int e = 0; e < DEPTH; e++)
      if (we[e]) mem[e] <= line[slot[e]];
  end
  // lanes index from head independently, so a lane pair may straddle lines and the wrap point
  always_comb begin
    for (int j = 0; j < DISP_W; j++) begin
      vld[j] = count > CW'(j);
      lanes[j] = vld[j] ? mem[AW'(head[AW-1:0] + AW'(j))] : '0;
    end
  end
  assign bus.o_fetch_rdy = rdy;
  assign bus.o_inst_vld = vld;
  assign bus.o_inst = lanes;
  assign bus.o_count = count;
  a_deq_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n || bus.i_flush)
    CW'(bus.i_deq_num) <= vld_cnt);
endmodule

// File: doc/inst_align_buf.md
INST_ALIGN_BUF -- requirements
Module: inst_align_buf

Interface
REQ-001 Parameter FETCH_W, default 4: instructions per fetch line; power of 2, >= 2.
REQ-002 Parameter DISP_W, default 2: dispatch lanes per cycle; 1 <= DISP_W <= FETCH_W.
REQ-003 Parameter DEPTH, default 8: buffer entries; power of 2, >= FETCH_W + DISP_W.
REQ-004 Clocking and reset SHALL be exactly: one clock; reset asynchronous, active-low.
REQ-005 i_clk  in  1  rising-edge clock.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_flush  in  1  discard all buffered instructions.
REQ-008 i_fetch_vld  in  1  fetch line present.
REQ-009 i_fetch_data  in  FETCH_W*`RV32_INST_WIDTH  line; slot k at bits [k*32 +: 32].
REQ-010 i_fetch_ofs  in  log2(FETCH_W)  first useful slot in line.
REQ-011 o_fetch_rdy  out  1  space for a full line.
REQ-012 o_inst_vld  out  DISP_W  per-lane valid, contiguous from lane 0.
REQ-013 o_inst  out  DISP_W*`RV32_INST_WIDTH  lane j at bits [j*32 +: 32].
REQ-014 i_deq_num  in  log2(DISP_W)+1  lanes consumed this cycle.
REQ-015 o_count  out  log2(DEPTH)+1  current occupancy.

Function
REQ-016 Buffer SHALL be a circular FIFO of DEPTH instruction entries with head, tail pointers (wrap modulo DEPTH) and occupancy count.
REQ-017 o_fetch_rdy SHALL be 1 iff DEPTH - count >= FETCH_W, from registered count only (no same-cycle dequeue credit).
REQ-018 Enqueue occurs when i_fetch_vld && o_fetch_rdy && !i_flush: slots i_fetch_ofs..FETCH_W-1 written in order at tail..tail+n-1, n = FETCH_W - i_fetch_ofs; tail += n.
REQ-019 i_fetch_vld with o_fetch_rdy=0 SHALL be ignored; fetch unit holds the line.
REQ-020 Lane j SHALL present entry head+j (mod DEPTH); o_inst_vld[j] = (count > j); invalid lanes drive 0.
REQ-021 Outputs SHALL be combinational from registered state; enqueued instructions visible the cycle after the enqueue edge (latency 1).
REQ-022 Dequeue: head += i_deq_num, count -= i_deq_num at the edge; i_deq_num > number of valid lanes is illegal (assertion) and clamps to valid count.
REQ-023 Simultaneous enqueue and dequeue: count_next = count + n - deq; entries dequeued and written never alias because of REQ-017.
REQ-024 Line wraparound SHALL not reduce dispatch width: a lane pair may span two fetch lines and DEPTH boundary (fixes slot-3 single-issue limit of prior selector).
REQ-025 i_flush SHALL take priority: head, tail, count set to 0 at the edge; concurrent enqueue and dequeue discarded.
REQ-026 Entry contents need no reset; only pointers and count are reset.

Reset
REQ-027 While i_rst_n=0: head=0, tail=0, count=0, hence o_inst_vld=0, o_inst=0, o_fetch_rdy=1, o_count=0.
REQ-028 Reset asserted mid-operation SHALL empty the buffer immediately, independent of i_clk; first enqueue permitted on the first edge after deassertion.

Structure
REQ-029 `RV32_INST_WIDTH and `IMEM_DATA_WIDTH SHALL come from constants.vh; FETCH_W*`RV32_INST_WIDTH SHALL equal `IMEM_DATA_WIDTH at top-level instantiation.
REQ-030 Pointer/count arithmetic in log2(DEPTH)+1 bits; pointers use low log2(DEPTH) bits.
REQ-031 One sub-module is natural: inst_align_wr (combinational per-entry write-enable and slot select from tail, i_fetch_ofs); read muxing stays in inst_align_buf.

Verification (FETCH_W=4, DISP_W=2, DEPTH=8)
REQ-032 Reset, then line {I3,I2,I1,I0} ofs=0 -> next cycle o_inst={I1,I0}, vld=2'b11, o_count=4.
REQ-033 Empty buffer, line ofs=3 (I3) -> vld=2'b01, lane0=I3; next line {J3..J0} ofs=0 with deq=1 -> next cycle lanes {J1,J0}, count=4.
REQ-034 Fill to count=5 with no dequeue -> o_fetch_rdy=0; line held for 3 cycles ignored; deq=2 -> count=3, o_fetch_rdy=1 following cycle.
REQ-035 Tail at 6, enqueue 4 entries -> entries 6,7,0,1 written; head at 7 shows lanes {entry0, entry7}.
REQ-036 i_flush with i_fetch_vld=1 and deq=2 same cycle -> count=0, vld=0, o_fetch_rdy=1 next cycle.
REQ-037 i_rst_n pulsed low between edges with count=6 -> vld=0, o_count=0 immediately.
